// File: rtl/gnw_loader_pkg.sv
// rtl/gnw_loader_pkg.sv - shared types for the ROM load sequencer
//
// Contents:
//   gnw_load_state_t : load sequencing states
//   gnw_load_entry_t : one buffered ioctl write (word address + data)
// The entry field widths bound the ADDR_WIDTH/DATA_WIDTH parameters of the top.
package gnw_loader_pkg;

    localparam int GNW_ADDR_WIDTH = 25;
    localparam int GNW_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        HOLD,
        RUN
    } gnw_load_state_t;

    typedef struct packed {
        logic [GNW_ADDR_WIDTH-1:0] addr;
        logic [GNW_DATA_WIDTH-1:0] data;
    } gnw_load_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - small first-word-fall-through FIFO for buffered ROM words
//
// Ports:
//   clk_sys_131_072 : clock
//   reset           : asynchronous active-high reset, empties the FIFO
//   push / din      : write din at the tail (caller guarantees room or a same-cycle pop)
//   pop             : drop the head (caller guarantees non-empty)
//   dout            : current head entry, valid whenever empty=0
//   count           : number of stored entries, 0..DEPTH
//   full / empty    : count==DEPTH / count==0
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                       clk_sys_131_072,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; a full push+pop writes the slot being read,
    // which is safe because the read is combinational before the edge.
    always_ff @(posedge clk_sys_131_072) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - buffers HPS ioctl ROM words into SDRAM writes and sequences core reset
//
// Ports:
//   clk_sys_131_072, reset         : clock, asynchronous active-high reset
//   ioctl_download/wr/addr/dout    : HPS download port (word-addressed writes)
//   ioctl_wait                     : backpressure to the HPS (FIFO nearly full)
//   sdram_wr_req/addr/data         : SDRAM write request, held with frozen addr/data until ack
//   sdram_ack                      : one-cycle write completion
//   has_rom, core_reset            : ROM-loaded flag and core reset request
//   overflow                       : sticky, a download write was dropped
module rom_load_sequencer
    import gnw_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                  clk_sys_131_072,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [DATA_WIDTH-1:0] ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  sdram_wr_req,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    input  logic                  sdram_ack,
    output logic                  has_rom,
    output logic                  core_reset,
    output logic                  overflow
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [FIFO_AW:0] WAIT_LEVEL = (FIFO_AW+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    gnw_load_state_t  state;
    gnw_load_state_t  state_next;
    gnw_load_entry_t  push_entry;
    gnw_load_entry_t  head_entry;

    logic [FIFO_AW:0] fifo_count;
    logic [FIFO_AW:0] next_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_strobe;
    logic             do_push;
    logic             do_pop;
    logic             download_q;
    logic             download_rise;
    logic             download_fall;
    logic [CNT_W-1:0] hold_cnt;

    // FIFO admission and issue decisions
    always_comb begin
        wr_strobe       = ioctl_wr & ioctl_download;
        do_pop          = ~sdram_wr_req & ~fifo_empty;
        // a full FIFO still takes the word when the head leaves this cycle
        do_push         = wr_strobe & (~fifo_full | do_pop);
        next_count      = fifo_count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
        push_entry.addr = GNW_ADDR_WIDTH'(ioctl_addr);
        push_entry.data = GNW_DATA_WIDTH'(ioctl_dout);
        download_rise   = ioctl_download & ~download_q;
        download_fall   = ~ioctl_download & download_q;
    end

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(gnw_load_entry_t))
    ) u_fifo (
        .clk_sys_131_072 (clk_sys_131_072),
        .reset           (reset),
        .push            (do_push),
        .pop             (do_pop),
        .din             (push_entry),
        .dout            (head_entry),
        .count           (fifo_count),
        .full            (fifo_full),
        .empty           (fifo_empty)
    );

    // SDRAM issue engine, HPS backpressure and overflow flag
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            sdram_wr_req <= 1'b0;
            sdram_addr   <= '0;
            sdram_data   <= '0;
            ioctl_wait   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            ioctl_wait <= (next_count >= WAIT_LEVEL);
            if (wr_strobe && !do_push) overflow <= 1'b1;
            // pop only while req is low, leaving one idle cycle between writes
            if (do_pop) begin
                sdram_wr_req <= 1'b1;
                sdram_addr   <= ADDR_WIDTH'(head_entry.addr);
                sdram_data   <= DATA_WIDTH'(head_entry.data);
            end else if (sdram_ack) begin
                sdram_wr_req <= 1'b0;
            end
        end
    end

    // Load sequencing state register
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            download_q <= 1'b0;
        end else begin
            state      <= state_next;
            download_q <= ioctl_download;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (download_rise) state_next = LOAD;
            LOAD:  if (download_fall) state_next = DRAIN;
            DRAIN: begin
                if (download_rise)                    state_next = LOAD;
                else if (fifo_empty && !sdram_wr_req) state_next = HOLD;
            end
            HOLD: begin
                if (download_rise)       state_next = LOAD;
                else if (hold_cnt == '0) state_next = RUN;
            end
            RUN:   if (download_rise) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Hold counter and registered core-facing outputs, updated on the transition edge
    always_ff @(posedge clk_sys_131_072 or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            has_rom    <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            if (state == DRAIN && state_next == HOLD) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            has_rom    <= (state_next == RUN);
            core_reset <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - scoreboard bench for rom_load_sequencer
module tb_rom_load_sequencer;

    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [DW-1:0] ioctl_dout = '0;
    logic          ioctl_wait;
    logic          sdram_wr_req;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data;
    logic          sdram_ack = 1'b0;
    logic          has_rom;
    logic          core_reset;
    logic          overflow;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks       = 0;
    int n_pass         = 0;
    int cyc            = 0;
    int ack_delay      = 0;
    int last_ack_cyc   = 0;
    int first_rise_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_load_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys_131_072 (clk),
        .reset           (reset),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_wait      (ioctl_wait),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_addr      (sdram_addr),
        .sdram_data      (sdram_data),
        .sdram_ack       (sdram_ack),
        .has_rom         (has_rom),
        .core_reset      (core_reset),
        .overflow        (overflow)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one write this cycle and advances one cycle.
    task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit honor_wait, input bit accepted);
        int guard = 0;
        exp_t e;
        if (honor_wait) begin
            while (ioctl_wait && guard < 200) begin
                step();
                guard++;
            end
            check_value("wait_release", 64'(guard < 200), 64'd1);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (accepted) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic wait_has_rom(output int rise);
        int g = 0;
        while (!has_rom && g < 600) begin
            step();
            g++;
        end
        check_value("has_rom_rise", 64'(has_rom), 64'd1);
        rise = cyc;
    endtask

    task automatic finish_load(output int rise);
        ioctl_download = 1'b0;
        wait_has_rom(rise);
        check_value("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // SDRAM responder: acks after ack_delay extra cycles of req
    initial begin : responder
        int ack_wait;
        ack_wait = 0;
        forever begin
            step();
            sdram_ack = 1'b0;
            if (reset || !sdram_wr_req) begin
                ack_wait = 0;
            end else if (ack_wait >= ack_delay) begin
                sdram_ack    = 1'b1;
                ack_wait     = 0;
                last_ack_cyc = cyc;
            end else begin
                ack_wait++;
            end
        end
    end

    // Monitor: each new request is compared to the scoreboard head, held requests must be stable
    initial begin : monitor
        logic          prev_req;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_data;
        exp_t          e;
        prev_req = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        forever begin
            step();
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (sdram_wr_req && !prev_req) begin
                    if (first_rise_cyc < 0) first_rise_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check_value("unexpected_write", 64'(sdram_addr), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_value("wr_addr", 64'(sdram_addr), 64'(e.addr));
                        check_value("wr_data", 64'(sdram_data), 64'(e.data));
                    end
                    cur_addr = sdram_addr;
                    cur_data = sdram_data;
                end else if (sdram_wr_req && prev_req) begin
                    check_value("hold_addr", 64'(sdram_addr), 64'(cur_addr));
                    check_value("hold_data", 64'(sdram_data), 64'(cur_data));
                end
                prev_req = sdram_wr_req;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rise;
        int wr0;
        int p;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_req",        64'(sdram_wr_req), 64'd0);
        check_value("rst_addr",       64'(sdram_addr),   64'd0);
        check_value("rst_data",       64'(sdram_data),   64'd0);
        check_value("rst_wait",       64'(ioctl_wait),   64'd0);
        check_value("rst_has_rom",    64'(has_rom),      64'd0);
        check_value("rst_core_reset", 64'(core_reset),   64'd1);
        check_value("rst_overflow",   64'(overflow),     64'd0);
        reset = 1'b0;

        // idle with no download
        for (int i = 0; i < 100; i++) begin
            step();
            check_value("idle_outputs", 64'({core_reset, has_rom, sdram_wr_req}), 64'b100);
        end

        // 8-word load, fast ack
        ack_delay      = 1;
        start_load();
        first_rise_cyc = -1;
        wr0            = cyc;
        for (int i = 0; i < 8; i++) wr_word(AW'(i), DW'(16'hA000 + i), 1'b1, 1'b1);
        finish_load(rise);
        check_value("first_req_latency", 64'(first_rise_cyc - wr0), 64'd2);
        check_value("hold_timing",       64'(rise - last_ack_cyc), 64'(HOLD + 2));
        check_value("run_core_reset",    64'(core_reset), 64'd0);

        // overflow: ioctl_wait ignored, slow ack
        ack_delay = 20;
        start_load();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) check_value("wait_below_level", 64'(ioctl_wait), 64'd0);
            if (i == 4) check_value("wait_at_level",    64'(ioctl_wait), 64'd1);
            if (i == 5) check_value("overflow_before",  64'(overflow),   64'd0);
            wr_word(AW'(16 + i), DW'(16'hB000 + i), 1'b0, i < 5);
        end
        check_value("overflow_set", 64'(overflow), 64'd1);
        finish_load(rise);
        check_value("overflow_sticky", 64'(overflow), 64'd1);

        // same traffic honouring ioctl_wait
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("overflow_cleared", 64'(overflow), 64'd0);
        start_load();
        for (int i = 0; i < 8; i++) wr_word(AW'(32 + i), DW'(16'hC000 + i), 1'b1, 1'b1);
        finish_load(rise);
        check_value("no_overflow", 64'(overflow), 64'd0);

        // reset while a write is pending in LOAD
        start_load();
        for (int i = 0; i < 4; i++) wr_word(AW'(48 + i), DW'(16'hD000 + i), 1'b0, 1'b1);
        check_value("pre_rst_req",  64'(sdram_wr_req), 64'd1);
        check_value("pre_rst_wait", 64'(ioctl_wait),   64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_value("async_rst_req",        64'(sdram_wr_req), 64'd0);
        check_value("async_rst_wait",       64'(ioctl_wait),   64'd0);
        check_value("async_rst_has_rom",    64'(has_rom),      64'd0);
        check_value("async_rst_core_reset", 64'(core_reset),   64'd1);
        exp_q.delete();
        ioctl_download = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (50) step();
        check_value("post_rst_no_req", 64'(sdram_wr_req), 64'd0);
        check_value("post_rst_state",  64'({core_reset, has_rom}), 64'b10);

        // second download started from RUN
        ack_delay = 0;
        start_load();
        for (int i = 0; i < 2; i++) wr_word(AW'(64 + i), DW'(16'hE000 + i), 1'b1, 1'b1);
        finish_load(rise);
        check_value("run_before_reload", 64'({has_rom, core_reset}), 64'b10);
        ioctl_download = 1'b1;
        step();
        check_value("reload_edge", 64'({has_rom, core_reset}), 64'b01);
        for (int i = 0; i < 3; i++) wr_word(AW'(80 + i), DW'(16'hF000 + i), 1'b1, 1'b1);
        finish_load(rise);
        check_value("reload_done_core_reset", 64'(core_reset), 64'd0);

        // single-cycle download pulse: empty load
        p = cyc;
        ioctl_download = 1'b1;
        step();
        ioctl_download = 1'b0;
        check_value("pulse_has_rom_low", 64'(has_rom), 64'd0);
        wait_has_rom(rise);
        check_value("pulse_timing", 64'(rise - p), 64'(HOLD + 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
